// File: rtl/zbuffer_depth_test.sv
// Depth-tested pixel writer: clears a Z memory, then runs rasterizer pixels through a 3-stage read/compare/write pipeline.
// Optional feature macro: ZBUF_CLEAR_COLOR_EN (also paints CLEAR_COLOR into the framebuffer while clearing).
module zbuffer_depth_test #(
    parameter int FB_HRES = 320,
    parameter int FB_VRES = 180,
    parameter int Z_BITS = 23,
    parameter int COLOR_WIDTH = 16,
    parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                frame_start_in,
    input  logic                                valid_in,
    output logic                                ready_out,
    input  logic [$clog2(FB_HRES)-1:0]          hcount_in,
    input  logic [$clog2(FB_VRES)-1:0]          vcount_in,
    input  logic [Z_BITS-1:0]                   z_in,
    input  logic [COLOR_WIDTH-1:0]              color_in,
    input  logic                                last_pixel_in,
    output logic                                fb_we_out,
    output logic [$clog2(FB_HRES*FB_VRES)-1:0]  fb_addr_out,
    output logic [COLOR_WIDTH-1:0]              fb_data_out,
    output logic                                busy_out,
    output logic                                frame_done_out
);

    localparam int H_BITS = $clog2(FB_HRES);
    localparam int V_BITS = $clog2(FB_VRES);
    localparam int N_PIX = FB_HRES * FB_VRES;
    localparam int A_BITS = $clog2(N_PIX);
    localparam int STAGES = 3;
    localparam logic [H_BITS:0] HRES_L = (H_BITS + 1)'(FB_HRES);
    localparam logic [V_BITS:0] VRES_L = (V_BITS + 1)'(FB_VRES);
    localparam logic [A_BITS-1:0] LAST_ADDR = A_BITS'(N_PIX - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

    state_t                 state_reg, state_next;
    logic [A_BITS-1:0]      clear_addr_reg, clear_addr_next;
    logic                   clear_we;

    logic [STAGES-1:0]      pipe_valid_reg;
    logic [STAGES-1:0]      pipe_in_range_reg;
    logic [A_BITS-1:0]      pipe_addr_reg  [STAGES];
    logic [Z_BITS-1:0]      pipe_z_reg     [STAGES];
    logic [COLOR_WIDTH-1:0] pipe_color_reg [STAGES];
    logic                   wr_reg;

    logic [Z_BITS-1:0]      depth_mem [N_PIX];
    logic [Z_BITS-1:0]      mem_q1_reg, mem_q2_reg;
    logic                   mem_we;
    logic [A_BITS-1:0]      mem_waddr;
    logic [Z_BITS-1:0]      mem_wdata;

    logic                   in_range;
    logic [A_BITS-1:0]      in_addr;
    logic [A_BITS-1:0]      rd_addr;
    logic [STAGES-1:0]      hit;
    logic                   run_ready;
    logic                   accept;
    logic                   pipe_empty;
    logic                   depth_pass;

    assign in_range = ({1'b0, hcount_in} < HRES_L) && ({1'b0, vcount_in} < VRES_L);
    assign in_addr  = A_BITS'(vcount_in) * A_BITS'(FB_HRES) + A_BITS'(hcount_in);
    assign rd_addr  = in_range ? in_addr : '0;

    // Off-screen pixels never touch memory, so they neither cause nor suffer address hazards.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_hazard
            assign hit[gi] = pipe_valid_reg[gi] && pipe_in_range_reg[gi] && in_range
                             && (pipe_addr_reg[gi] == in_addr);
        end
    endgenerate

    assign run_ready  = ~|hit;
    assign pipe_empty = ~|pipe_valid_reg;
    assign accept     = valid_in && ready_out;
    assign depth_pass = pipe_valid_reg[1] && pipe_in_range_reg[1] && (pipe_z_reg[1] < mem_q2_reg);

    always_comb begin
        state_next      = state_reg;
        clear_addr_next = clear_addr_reg;
        clear_we        = 1'b0;
        ready_out       = 1'b0;
        busy_out        = 1'b0;
        frame_done_out  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_start_in) begin
                    state_next      = CLEAR;
                    clear_addr_next = '0;
                end
            end
            CLEAR: begin
                busy_out = 1'b1;
                clear_we = 1'b1;
                if (clear_addr_reg == LAST_ADDR) begin
                    state_next      = RUN;
                    clear_addr_next = '0;
                end else begin
                    clear_addr_next = clear_addr_reg + 1'b1;
                end
            end
            RUN: begin
                busy_out  = 1'b1;
                ready_out = run_ready;
                if (valid_in && run_ready && last_pixel_in) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy_out = 1'b1;
                if (pipe_empty) begin
                    frame_done_out = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (rst_in) begin
            clear_we       = 1'b0;
            ready_out      = 1'b0;
            busy_out       = 1'b0;
            frame_done_out = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg      <= IDLE;
            clear_addr_reg <= '0;
            pipe_valid_reg <= '0;
            wr_reg         <= 1'b0;
        end else begin
            state_reg      <= state_next;
            clear_addr_reg <= clear_addr_next;
            pipe_valid_reg <= {pipe_valid_reg[STAGES-2:0], accept};
            wr_reg         <= depth_pass;
        end
    end

    always_ff @(posedge clk_in) begin
        pipe_in_range_reg <= {pipe_in_range_reg[STAGES-2:0], in_range};
        pipe_addr_reg[0]  <= in_addr;
        pipe_z_reg[0]     <= z_in;
        pipe_color_reg[0] <= color_in;
        for (int i = 1; i < STAGES; i++) begin
            pipe_addr_reg[i]  <= pipe_addr_reg[i-1];
            pipe_z_reg[i]     <= pipe_z_reg[i-1];
            pipe_color_reg[i] <= pipe_color_reg[i-1];
        end
    end

    // Pipeline writes win the single port; the clear never overlaps a live pipeline.
    assign mem_we    = (wr_reg && !rst_in) || clear_we;
    assign mem_waddr = wr_reg ? pipe_addr_reg[STAGES-1] : clear_addr_reg;
    assign mem_wdata = wr_reg ? pipe_z_reg[STAGES-1] : '1;

    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            depth_mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_in) begin
        mem_q1_reg <= depth_mem[rd_addr];
        mem_q2_reg <= mem_q1_reg;
    end

    always_comb begin
        fb_we_out   = wr_reg;
        fb_addr_out = pipe_addr_reg[STAGES-1];
        fb_data_out = pipe_color_reg[STAGES-1];
        if (state_reg == CLEAR) begin
            fb_addr_out = clear_addr_reg;
            fb_data_out = CLEAR_COLOR;
`ifdef ZBUF_CLEAR_COLOR_EN
            fb_we_out   = 1'b1;
`else
            fb_we_out   = 1'b0;
`endif
        end
        if (rst_in) begin
            fb_we_out   = 1'b0;
            fb_addr_out = '0;
            fb_data_out = '0;
        end
    end

endmodule

// File: tb/tb_zbuffer_depth_test.sv
// Scoreboard bench for zbuffer_depth_test on a 320x10 framebuffer; expected writes are queued by the driver and checked by a monitor.
module tb_zbuffer_depth_test;

    localparam int HRES = 320;
    localparam int VRES = 10;
    localparam int ZB = 23;
    localparam int CW = 16;
    localparam int HB = 9;
    localparam int VB = 4;
    localparam int AW = 12;
    localparam int N_PIX = 3200;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          valid;
    logic          ready;
    logic [HB-1:0] hcount;
    logic [VB-1:0] vcount;
    logic [ZB-1:0] z;
    logic [CW-1:0] color;
    logic          last_pixel;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [CW-1:0] fb_data;
    logic          busy;
    logic          frame_done;

    always #5 clk = ~clk;

    zbuffer_depth_test #(
        .FB_HRES(HRES), .FB_VRES(VRES), .Z_BITS(ZB), .COLOR_WIDTH(CW), .CLEAR_COLOR(16'h1234)
    ) dut (
        .clk_in(clk), .rst_in(rst), .frame_start_in(frame_start), .valid_in(valid),
        .ready_out(ready), .hcount_in(hcount), .vcount_in(vcount), .z_in(z),
        .color_in(color), .last_pixel_in(last_pixel), .fb_we_out(fb_we),
        .fb_addr_out(fb_addr), .fb_data_out(fb_data), .busy_out(busy),
        .frame_done_out(frame_done)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (fb_we) begin
            $display("[TB] write cycle %0d addr %0d data 0x%h", cyc, fb_addr, fb_data);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%h, required no write", fb_addr, fb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("write_cycle", 64'(cyc), 64'(e.cyc));
                check("write_addr", 64'(fb_addr), 64'(e.addr));
                check("write_data", 64'(fb_data), 64'(e.data));
            end
        end
    end

    task automatic expect_write(input int acc, input int addr, input int data);
        exp_t e;
        e.cyc  = acc + 3;
        e.addr = AW'(addr);
        e.data = CW'(data);
        exp_q.push_back(e);
    endtask

    // Presents a pixel until accepted; returns acceptance cycle and stall count. Ends at posedge+1.
    task automatic send(input int h, input int v, input int zz, input int c, input bit last,
                        output int acc, output int stalls);
        hcount = HB'(h);
        vcount = VB'(v);
        z = ZB'(zz);
        color = CW'(c);
        last_pixel = last;
        valid = 1'b1;
        acc = -1;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) begin
                acc = cyc;
                @(posedge clk);
                #1;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        last_pixel = 1'b0;
        if (acc < 0) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: pixel (%0d,%0d) got no ready, required ready within 20 cycles", h, v);
            acc = 0;
        end else begin
            $display("[TB] pixel h=%0d v=%0d z=%0d color=0x%h accepted cycle %0d after %0d stalls",
                     h, v, zz, c, acc, stalls);
        end
    endtask

    task automatic start_frame(input string name);
        int n;
        int k;
        @(posedge clk);
        #1;
        k = cyc;
        frame_start = 1'b1;
`ifdef ZBUF_CLEAR_COLOR_EN
        for (int i = 0; i < N_PIX; i++) begin
            exp_t e;
            e.cyc = k + 1 + i;
            e.addr = AW'(i);
            e.data = 16'h1234;
            exp_q.push_back(e);
        end
`endif
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        n = 0;
        for (int i = 0; i < N_PIX + 20; i++) begin
            @(negedge clk);
            if (ready) break;
            if (busy) n++;
        end
        check({name, "_clear_cycles"}, 64'(n), 64'(N_PIX));
        check({name, "_busy_in_run"}, 64'(busy), 64'd1);
        check({name, "_ready_after_clear"}, 64'(ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int st;
        int pulses;
        int done_cyc;

        rst = 1'b1;
        frame_start = 1'b0;
        valid = 1'b0;
        hcount = '0;
        vcount = '0;
        z = '0;
        color = '0;
        last_pixel = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_fb_we", 64'(fb_we), 64'd0);
        check("rst_fb_addr", 64'(fb_addr), 64'd0);
        check("rst_fb_data", 64'(fb_data), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(ready), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        valid = 1'b0;

        start_frame("frame1");

        // frame_start in RUN must not restart the clear
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        @(negedge clk);
        check("start_ignored_ready", 64'(ready), 64'd1);
        check("start_ignored_busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;

        send(5, 2, 100, 'hABCD, 1'b0, acc, st);
        check("p1_stalls", 64'(st), 64'd0);
        expect_write(acc, 645, 'hABCD);
        send(5, 2, 50, 'h1111, 1'b0, acc, st);
        check("p2_hazard_stalls", 64'(st), 64'd3);
        expect_write(acc, 645, 'h1111);
        send(5, 2, 50, 'h2222, 1'b0, acc, st);
        check("p3_hazard_stalls", 64'(st), 64'd3);
        send(5, 2, 200, 'h3333, 1'b0, acc, st);
        check("p4_hazard_stalls", 64'(st), 64'd3);
        repeat (4) @(posedge clk);
        #1;

        send(0, 0, 10, 'h0001, 1'b0, acc, st);
        check("b2b_0_stalls", 64'(st), 64'd0);
        expect_write(acc, 0, 'h0001);
        send(319, 9, 10, 'h0002, 1'b0, acc, st);
        check("b2b_1_stalls", 64'(st), 64'd0);
        expect_write(acc, 3199, 'h0002);
        send(1, 0, 7, 'h0003, 1'b0, acc, st);
        check("b2b_2_stalls", 64'(st), 64'd0);
        expect_write(acc, 1, 'h0003);
        send(0, 1, 7, 'h0004, 1'b0, acc, st);
        check("b2b_3_stalls", 64'(st), 64'd0);
        expect_write(acc, 320, 'h0004);
        send(320, 0, 1, 'hDEAD, 1'b0, acc, st);
        check("oor_h_stalls", 64'(st), 64'd0);
        send(0, 10, 1, 'hBEEF, 1'b0, acc, st);
        check("oor_v_stalls", 64'(st), 64'd0);
        send(0, 0, 10, 'h7777, 1'b0, acc, st);
        check("equal_z_stalls", 64'(st), 64'd0);
        send(1, 0, 6, 'h8888, 1'b0, acc, st);
        expect_write(acc, 1, 'h8888);

        send(10, 5, 5, 'h5555, 1'b1, acc, st);
        expect_write(acc, 1610, 'h5555);
        pulses = 0;
        done_cyc = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (frame_done) begin
                pulses++;
                done_cyc = cyc;
            end
        end
        check("frame_done_pulses", 64'(pulses), 64'd1);
        check("frame_done_cycle", 64'(done_cyc), 64'(acc + 4));
        check("done_busy", 64'(busy), 64'd0);
        check("frame1_queue_empty", 64'(exp_q.size()), 64'd0);

        start_frame("frame2");
        send(20, 3, 1, 'h0A0A, 1'b0, acc, st);
        send(21, 3, 1, 'h0B0B, 1'b0, acc, st);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrun_rst_fb_we", 64'(fb_we), 64'd0);
            check("midrun_rst_busy", 64'(busy), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid = 1'b1;
        repeat (5) @(negedge clk);
        check("after_rst_idle_busy", 64'(busy), 64'd0);
        check("after_rst_idle_ready", 64'(ready), 64'd0);
        valid = 1'b0;
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
